// File: rtl/sra_issue_queue.sv
// sra_issue_queue: operand FIFO feeding a fixed-latency SRA core, one operation in flight
// Ports: clk_i/reset_i clock and asynchronous active-high reset; in_valid_i/in_ready_o/
// in_a_i/in_b_i upstream operand pairs; sra_input1_o/sra_input2_o/sra_start_o/sra_result_i
// launch and result interface to the core; out_valid_o/out_ready_i/out_data_o downstream
// result handshake; busy_o high while an operation is in flight or operands are queued.
module sra_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 12
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_a_i,
    input  logic [7:0] in_b_i,
    output logic [7:0] sra_input1_o,
    output logic [7:0] sra_input2_o,
    output logic       sra_start_o,
    input  logic [7:0] sra_result_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic       busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
    state_t        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic [7:0]    cnt_q, cnt_d, in1_q, in1_d, in2_q, in2_d, data_q, data_d;
    logic          valid_q, valid_d, push, pop;
    assign in_ready_o   = count_q != CW'(DEPTH);
    assign push         = in_valid_i && in_ready_o;
    assign pop          = state_q == IDLE && count_q != '0 && (!valid_q || out_ready_i);
    assign sra_input1_o = in1_q;
    assign sra_input2_o = in2_q;
    assign sra_start_o  = state_q == LAUNCH;
    assign out_valid_o  = valid_q;
    assign out_data_o   = data_q;
    assign busy_o       = state_q != IDLE || count_q != '0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        data_d  = data_q;
        valid_d = valid_q && !out_ready_i;
        case (state_q)
            IDLE: if (pop) begin
                state_d        = LAUNCH;
                {in1_d, in2_d} = mem_q[rd_q];
            end
            LAUNCH: begin
                state_d = WAIT;
                cnt_d   = 8'(LATENCY - 1);
            end
            WAIT: if (cnt_q == '0) begin
                state_d = HOLD;
                data_d  = sra_result_i;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            HOLD: if (valid_q && out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_q + CW'(push) - CW'(pop);
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
        end
    end
    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= {in_a_i, in_b_i};
    end
endmodule

// File: tb/tb_sra_issue_queue.sv
// tb_sra_issue_queue: randomized and directed bench for sra_issue_queue with a core stub
module tb_sra_issue_queue;
    localparam int DEPTH = 4;
    localparam int LAT   = 12;
    logic       clk = 1'b0, rst = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_a = '0, in_b = '0;
    logic       in_ready, sra_start, out_valid, busy;
    logic [7:0] sra_in1, sra_in2, sra_result, out_data;
    int         checks = 0, passed = 0;
    int         n, cnt;

    always #5 clk = ~clk;

    sra_issue_queue #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .sra_input1_o(sra_in1), .sra_input2_o(sra_in2),
        .sra_start_o(sra_start), .sra_result_i(sra_result), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .busy_o(busy)
    );

    function automatic logic [7:0] sra(input logic [7:0] a, input logic [7:0] b);
        logic signed [7:0] s;
        s = a;
        return s >>> b[2:0];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Core stub: result becomes valid LAT edges after the edge that samples the start
    // pulse; before that it drives a poison value so an early capture is visible.
    int         stub_cnt;
    logic       stub_armed;
    logic [7:0] stub_val;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_cnt   <= 0;
            stub_armed <= 1'b0;
            stub_val   <= '0;
        end else if (sra_start) begin
            stub_cnt   <= LAT - 1;
            stub_armed <= 1'b1;
            stub_val   <= sra(sra_in1, sra_in2);
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end
    assign sra_result = (stub_armed && stub_cnt == 0) ? stub_val : 8'hEE;

    // Reference model: a queue of pending pairs, one in-flight op tracked by its age
    // in clocks since it was popped, and a held result awaiting handshake.
    logic [15:0] mq[$];
    bit          m_act = 0, m_ov = 0;
    int          m_age = 0;
    logic [7:0]  m_in1 = '0, m_in2 = '0, m_od = '0;
    logic [7:0]  got[$];
    always @(posedge clk or posedge rst) begin : model
        bit do_pop, do_push;
        if (rst) begin
            mq.delete();
            m_act = 0;
            m_ov  = 0;
            m_age = 0;
            m_in1 = '0;
            m_in2 = '0;
            m_od  = '0;
        end else begin
            do_push = in_valid && mq.size() < DEPTH;
            do_pop  = !m_act && !m_ov && mq.size() > 0;
            if (m_ov && out_ready) m_ov = 0;
            if (m_act) begin
                if (m_age == LAT) begin
                    m_act = 0;
                    m_ov  = 1;
                    m_od  = sra(m_in1, m_in2);
                end else begin
                    m_age++;
                end
            end
            if (do_pop) begin
                {m_in1, m_in2} = mq.pop_front();
                m_act = 1;
                m_age = 0;
            end
            if (do_push) mq.push_back({in_a, in_b});
        end
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back(out_data);
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, int'(mq.size() < DEPTH));
            chk("sra_start", sra_start, int'(m_act && m_age == 0));
            chk("sra_input1", sra_in1, m_in1);
            chk("sra_input2", sra_in2, m_in2);
            chk("out_valid", out_valid, int'(m_ov));
            chk("out_data", out_data, m_od);
            chk("busy", busy, int'(m_act || m_ov || mq.size() > 0));
        end
    end

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = r;
    endtask

    task automatic settle();
        for (int k = 0; k < 300 && (busy || out_valid); k++) drive(0, 0, 0, 1);
        chk("settle_timeout", busy, 0);
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_start"}, sra_start, 0);
        chk({tag, "_in1"}, sra_in1, 0);
        chk({tag, "_in2"}, sra_in2, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] fa[5];
        logic [7:0] fb[5];
        fa = '{8'h80, 8'h7F, 8'hA5, 8'h3C, 8'h81};
        fb = '{8'h01, 8'h03, 8'h02, 8'h05, 8'h07};
        repeat (2) @(negedge clk);
        reset_literals("reset");
        rst = 1'b0;

        // Single operation: latency counted from the edge sampling start to the edge raising valid
        drive(1, 8'hF0, 8'h02, 1);
        n = 0;
        while (!sra_start && n < 50) begin drive(0, 0, 0, 1); n++; end
        chk("single_start_seen", sra_start, 1);
        n = 0;
        while (!out_valid && n < 50) begin drive(0, 0, 0, 1); n++; end
        chk("single_latency", n - 1, LAT);
        chk("single_data", out_data, 8'hFC);
        settle();

        // Queue fill with output stalled, then backpressure
        got.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1, fa[i], fb[i], 0);
            if (i == 4) chk("fill_ready_before_5th", in_ready, 1);
        end
        drive(0, 0, 0, 0);
        chk("fill_ready_low", in_ready, 0);
        n = 0;
        while (!out_valid && n < 50) begin drive(0, 0, 0, 0); n++; end
        cnt = 0;
        repeat (20) begin drive(0, 0, 0, 0); cnt += int'(sra_start); end
        chk("bp_no_start", cnt, 0);
        chk("bp_data", out_data, 8'hC0);
        chk("bp_valid", out_valid, 1);
        drive(0, 0, 0, 1);
        n = 0;
        while (!sra_start && n < 50) begin drive(0, 0, 0, 1); n++; end
        chk("relaunch_gap", n, 2);
        settle();
        chk("fill_count", got.size(), 5);
        chk("fill_order0", got.size() > 0 ? got[0] : 0, 8'hC0);
        chk("fill_order1", got.size() > 1 ? got[1] : 0, 8'h0F);

        // Reset while waiting on the core with two entries queued
        drive(1, 8'h11, 8'h01, 1);
        drive(1, 8'h22, 8'h02, 1);
        drive(1, 8'h33, 8'h03, 1);
        chk("rst_start_seen", sra_start, 1);
        repeat (5) drive(0, 0, 0, 1);
        chk("pre_reset_count", dut.count_q, 2);
        #2 rst = 1'b1;
        #1 reset_literals("midwait");
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (40) begin drive(0, 0, 0, 1); cnt += int'(out_valid); end
        chk("no_ov_after_reset", cnt, 0);

        // First push lands on the first edge after reset release
        #2 rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_a     = 8'h5A;
        in_b     = 8'h01;
        @(negedge clk);
        chk("first_edge_push", dut.count_q, 1);
        settle();

        // Push in the same cycle as an IDLE -> LAUNCH pop with two entries queued
        got.delete();
        drive(1, 8'h44, 8'h01, 0);
        drive(1, 8'h55, 8'h02, 0);
        drive(1, 8'h66, 8'h03, 0);
        n = 0;
        while (!out_valid && n < 50) begin drive(0, 0, 0, 0); n++; end
        drive(0, 0, 0, 1);
        drive(1, 8'h77, 8'h04, 0);
        chk("simul_count_before", dut.count_q, 2);
        drive(0, 0, 0, 0);
        chk("simul_count_after", dut.count_q, 2);
        chk("simul_in1", sra_in1, 8'h55);
        settle();
        chk("simul_results", got.size(), 4);
        chk("simul_order1", got.size() > 1 ? got[1] : 0, 8'h15);
        chk("simul_order3", got.size() > 3 ? got[3] : 0, 8'h07);

        // Randomized traffic against the model
        repeat (1500) drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                            $urandom_range(0, 3) != 0);
        settle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
